load_hazard_scoreboard: RTL and testbench

LOAD_HAZARD_SCOREBOARD -- requirements
Module: load_hazard_scoreboard

---
 rtl/load_hazard_scoreboard.sv | 75 +++++++
 tb/tb_load_hazard_scoreboard.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/load_hazard_scoreboard.sv
// Load-use hazard scoreboard: one countdown per register tracks in-flight loads,
// and decode stalls while any read operand still waits on its load data.
module load_hazard_scoreboard #(
  parameter int unsigned REG_AW   = 4,
  parameter int unsigned NSRC     = 2,
  parameter int unsigned LOAD_LAT = 1,
  parameter int unsigned CNT_W    = 16,
  parameter int unsigned ZERO_REG = 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NSRC*REG_AW-1:0] src_addr,
  input  logic [NSRC-1:0]        src_re,
  input  logic                   issue_valid,
  input  logic [REG_AW-1:0]      dst_addr,
  input  logic                   dst_we,
  input  logic                   is_load,
  input  logic                   flush,
  output logic                   nop_mux,
  output logic                   f_reg_en,
  output logic                   pc_en,
  output logic [CNT_W-1:0]       stall_count
);

  localparam int unsigned NREG = 2 ** REG_AW;
  localparam int unsigned PW   = $clog2(LOAD_LAT + 1);
  localparam logic [PW-1:0] LAT_VAL = PW'(LOAD_LAT);

  logic [PW-1:0]     pend [NREG];
  logic              hazard;
  logic              stall;
  logic              issue;
  logic              dst_is_zero;
  logic [REG_AW-1:0] addr;

  always_comb begin
    hazard = 1'b0;
    addr   = '0;
    for (int unsigned i = 0; i < NSRC; i++) begin
      addr = src_addr[i*REG_AW +: REG_AW];
      if (src_re[i] && (pend[addr] != '0) && !((ZERO_REG != 0) && (addr == '0)))
        hazard = 1'b1;
    end
  end

  assign stall       = hazard && issue_valid && !flush;
  assign issue       = issue_valid && !flush && !stall;
  assign dst_is_zero = (ZERO_REG != 0) && (dst_addr == '0);

  assign nop_mux  = stall;
  assign f_reg_en = !stall;
  assign pc_en    = !stall;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned r = 0; r < NREG; r++)
        pend[r] <= '0;
      stall_count <= '0;
    end else begin
      for (int unsigned r = 0; r < NREG; r++)
        if (pend[r] != '0)
          pend[r] <= pend[r] - PW'(1);
      // Later assignment wins, so an issuing writer overrides its own decrement.
      if (issue && dst_we) begin
        if (!is_load)
          pend[dst_addr] <= '0;
        else if (!dst_is_zero)
          pend[dst_addr] <= LAT_VAL;
      end
      if (stall && (stall_count != '1))
        stall_count <= stall_count + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_load_hazard_scoreboard.sv
// Bench: two scoreboard configurations share one stimulus stream and are compared
// against a model that tracks the cycle at which each register's load data is ready.
module tb_load_hazard_scoreboard;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  src_addr = '0;
  logic [1:0]  src_re = '0;
  logic        issue_valid = 1'b0;
  logic [3:0]  dst_addr = '0;
  logic        dst_we = 1'b0;
  logic        is_load = 1'b0;
  logic        flush = 1'b0;

  logic        nop_a, freg_a, pc_a;
  logic [2:0]  cnt_a;
  logic        nop_b, freg_b, pc_b;
  logic [15:0] cnt_b;

  int checks = 0;
  int errors = 0;

  longint ready [2][16];
  int     cnt_m [2];
  longint cyc = 0;
  bit     st [2];
  bit     iss [2];

  always #5 clk = ~clk;

  load_hazard_scoreboard #(.REG_AW(4), .NSRC(2), .LOAD_LAT(3), .CNT_W(3), .ZERO_REG(1)) dut_a (
    .clk(clk), .rst(rst), .src_addr(src_addr), .src_re(src_re), .issue_valid(issue_valid),
    .dst_addr(dst_addr), .dst_we(dst_we), .is_load(is_load), .flush(flush),
    .nop_mux(nop_a), .f_reg_en(freg_a), .pc_en(pc_a), .stall_count(cnt_a)
  );

  load_hazard_scoreboard #(.REG_AW(4), .NSRC(2), .LOAD_LAT(1), .CNT_W(16), .ZERO_REG(0)) dut_b (
    .clk(clk), .rst(rst), .src_addr(src_addr), .src_re(src_re), .issue_valid(issue_valid),
    .dst_addr(dst_addr), .dst_we(dst_we), .is_load(is_load), .flush(flush),
    .nop_mux(nop_b), .f_reg_en(freg_b), .pc_en(pc_b), .stall_count(cnt_b)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic int lat_of(int k);
    return (k == 0) ? 3 : 1;
  endfunction

  function automatic int cmax_of(int k);
    return (k == 0) ? 7 : 65535;
  endfunction

  function automatic bit model_hazard(int k);
    logic [3:0] a;
    for (int i = 0; i < 2; i++) begin
      a = src_addr[i*4 +: 4];
      if (src_re[i] && (ready[k][a] > cyc) && !(k == 0 && a == 4'd0))
        return 1'b1;
    end
    return 1'b0;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      for (int r = 0; r < 16; r++) ready[k][r] = 0;
      cnt_m[k] = 0;
    end
  endtask

  task automatic drive(input logic [3:0] s0, input logic [3:0] s1, input logic [1:0] re,
                       input logic iv, input logic [3:0] d, input logic we,
                       input logic ld, input logic fl);
    src_addr    = {s1, s0};
    src_re      = re;
    issue_valid = iv;
    dst_addr    = d;
    dst_we      = we;
    is_load     = ld;
    flush       = fl;
  endtask

  // Inputs are already applied after a falling edge; check, then step the model across the rising edge.
  task automatic run_cycle(input string tag);
    #1;
    for (int k = 0; k < 2; k++) begin
      st[k]  = model_hazard(k) && issue_valid && !flush;
      iss[k] = issue_valid && !flush && !st[k];
    end
    check_eq({tag, "_nop_a"},  32'(nop_a),  32'(st[0]));
    check_eq({tag, "_freg_a"}, 32'(freg_a), 32'(!st[0]));
    check_eq({tag, "_pc_a"},   32'(pc_a),   32'(!st[0]));
    check_eq({tag, "_cnt_a"},  32'(cnt_a),  32'(cnt_m[0]));
    check_eq({tag, "_nop_b"},  32'(nop_b),  32'(st[1]));
    check_eq({tag, "_freg_b"}, 32'(freg_b), 32'(!st[1]));
    check_eq({tag, "_pc_b"},   32'(pc_b),   32'(!st[1]));
    check_eq({tag, "_cnt_b"},  32'(cnt_b),  32'(cnt_m[1]));
    @(posedge clk);
    for (int k = 0; k < 2; k++) begin
      if (st[k] && cnt_m[k] < cmax_of(k)) cnt_m[k]++;
      if (iss[k] && dst_we) begin
        if (!is_load) ready[k][dst_addr] = 0;
        else if (!(k == 0 && dst_addr == 4'd0)) ready[k][dst_addr] = cyc + 1 + lat_of(k);
      end
    end
    cyc++;
    @(negedge clk);
  endtask

  task automatic do_reset(input string tag);
    rst = 1'b1;
    #1;
    check_eq({tag, "_nop_a"},  32'(nop_a),  32'd0);
    check_eq({tag, "_freg_a"}, 32'(freg_a), 32'd1);
    check_eq({tag, "_pc_a"},   32'(pc_a),   32'd1);
    check_eq({tag, "_cnt_a"},  32'(cnt_a),  32'd0);
    check_eq({tag, "_nop_b"},  32'(nop_b),  32'd0);
    check_eq({tag, "_freg_b"}, 32'(freg_b), 32'd1);
    check_eq({tag, "_pc_b"},   32'(pc_b),   32'd1);
    check_eq({tag, "_cnt_b"},  32'(cnt_b),  32'd0);
    model_reset();
    @(posedge clk);
    cyc++;
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    model_reset();
    do_reset("por");

    // Load r3 then hold a dependent reader: 3 bubbles on A, 1 on B.
    drive(4'd0, 4'd0, 2'b00, 1'b1, 4'd3, 1'b1, 1'b1, 1'b0); run_cycle("ld_r3");
    repeat (4) begin
      drive(4'd3, 4'd0, 2'b01, 1'b1, 4'd0, 1'b0, 1'b0, 1'b0); run_cycle("use_r3");
    end
    check_eq("cnt_a_lat3", 32'(cnt_a), 32'd3);
    check_eq("cnt_b_lat1", 32'(cnt_b), 32'd1);

    // Register 0: ignored on A, a real register on B.
    drive(4'd0, 4'd0, 2'b00, 1'b1, 4'd0, 1'b1, 1'b1, 1'b0); run_cycle("ld_r0");
    repeat (2) begin
      drive(4'd9, 4'd0, 2'b10, 1'b1, 4'd0, 1'b0, 1'b0, 1'b0); run_cycle("use_r0");
    end

    // Flush hides the stall but the countdown keeps running.
    drive(4'd0, 4'd0, 2'b00, 1'b1, 4'd2, 1'b1, 1'b1, 1'b0); run_cycle("ld_r2");
    drive(4'd2, 4'd0, 2'b01, 1'b1, 4'd0, 1'b0, 1'b0, 1'b1); run_cycle("flush_r2");
    repeat (3) begin
      drive(4'd2, 4'd0, 2'b01, 1'b1, 4'd0, 1'b0, 1'b0, 1'b0); run_cycle("use_r2");
    end

    // Younger ALU write supersedes an in-flight load.
    drive(4'd0, 4'd0, 2'b00, 1'b1, 4'd4, 1'b1, 1'b1, 1'b0); run_cycle("ld_r4");
    drive(4'd1, 4'd6, 2'b11, 1'b1, 4'd4, 1'b1, 1'b0, 1'b0); run_cycle("alu_r4");
    drive(4'd4, 4'd4, 2'b11, 1'b1, 4'd9, 1'b0, 1'b0, 1'b0); run_cycle("use_r4");
    check_eq("alu_r4_no_stall", 32'(nop_a), 32'd0);

    // Source equal to destination sees pre-update state.
    drive(4'd5, 4'd0, 2'b01, 1'b1, 4'd5, 1'b1, 1'b1, 1'b0); run_cycle("self_r5");
    repeat (4) begin
      drive(4'd0, 4'd5, 2'b10, 1'b1, 4'd0, 1'b0, 1'b0, 1'b0); run_cycle("use_r5");
    end

    // Push A's 3-bit counter into saturation.
    repeat (3) begin
      drive(4'd0, 4'd0, 2'b00, 1'b1, 4'd7, 1'b1, 1'b1, 1'b0); run_cycle("ld_r7");
      repeat (4) begin
        drive(4'd7, 4'd7, 2'b11, 1'b1, 4'd0, 1'b0, 1'b0, 1'b0); run_cycle("use_r7");
      end
    end
    check_eq("cnt_a_sat", 32'(cnt_a), 32'd7);

    // Reset in the middle of a stall.
    drive(4'd0, 4'd0, 2'b00, 1'b1, 4'd7, 1'b1, 1'b1, 1'b0); run_cycle("ld_r7b");
    drive(4'd7, 4'd0, 2'b01, 1'b1, 4'd0, 1'b0, 1'b0, 1'b0);
    #1;
    check_eq("pre_rst_stall_a", 32'(nop_a), 32'd1);
    do_reset("mid_rst");
    run_cycle("post_rst");

    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 199) == 0) begin
        do_reset("rnd_rst");
      end else begin
        drive(4'($urandom_range(0, 7)), 4'($urandom_range(0, 7)), 2'($urandom_range(0, 3)),
              1'($urandom_range(0, 7) != 0), 4'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
              1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 9) == 0));
        run_cycle("rnd");
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
